// File: rtl/spm_pkg.sv
// ---------------------------------------------------------------------------
// spm_pkg
// Shared definitions for the signed serial-parallel multiplier controller:
//   - state_t     : controller FSM states (IDLE, MUL, FIX)
//   - SPM_N       : default operand width in bits
//   - SPM_P       : derived product width (2*SPM_N)
// ---------------------------------------------------------------------------
package spm_pkg;

    localparam int SPM_N = 8;
    localparam int SPM_P = 2 * SPM_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/spm_shift_add_core.sv
// ---------------------------------------------------------------------------
// spm_shift_add_core
// Unsigned shift-add magnitude multiplier datapath. One multiplier bit is
// consumed per i_step cycle; after N steps o_acc holds i_mcand * multiplier.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   i_load    in   clear accumulator and load the multiplier shift register
//   i_step    in   perform one conditional add + shift
//   i_mcand   in   N-bit unsigned multiplicand, held stable during steps
//   i_mplier  in   N-bit unsigned multiplier, captured on i_load
//   o_acc     out  2N-bit accumulator
// ---------------------------------------------------------------------------
module spm_shift_add_core
    import spm_pkg::*;
#(
    parameter int N = SPM_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [N-1:0]     i_mcand,
    input  logic [N-1:0]     i_mplier,
    output logic [2*N-1:0]   o_acc
);

    logic [2*N-1:0] r_acc;
    logic [N-1:0]   r_mplier;
    logic [N:0]     w_sum;

    // Upper half plus the (possibly gated) multiplicand; the extra bit keeps
    // the carry-out, which becomes the new MSB after the right shift.
    assign w_sum = {1'b0, r_acc[2*N-1:N]} + (r_mplier[0] ? {1'b0, i_mcand} : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mplier <= i_mplier;
        end else if (i_step) begin
            r_acc    <= {w_sum, r_acc[N-1:1]};
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/spm_signed_ctrl.sv
// ---------------------------------------------------------------------------
// spm_signed_ctrl
// Sequencing controller for a signed NxN serial-parallel multiplier. Converts
// operands to sign/magnitude, runs N shift-add cycles in spm_shift_add_core,
// then negates the magnitude product in a single FIX cycle when signs differ.
//
// Handshake: start is a request sampled only in IDLE (ignored while busy).
// Acceptance is implied by busy rising on the next cycle. done is a one-cycle
// registered pulse; product is valid from that cycle and holds until the next
// done. A start held high through the done cycle begins the next operation.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   operation request
//   multiplicand  in   N-bit signed operand A
//   multiplier    in   N-bit signed operand B
//   sgn_mode      in   (only with SPM_UNSIGNED_MODE_EN) 1=signed, 0=unsigned
//   busy          out  high while not IDLE
//   done          out  one-cycle completion pulse
//   product       out  2N-bit result
//   o_dbg_state   out  current FSM state (debug visibility)
//
// Build option: define SPM_UNSIGNED_MODE_EN to add the sgn_mode input.
// ---------------------------------------------------------------------------
module spm_signed_ctrl
    import spm_pkg::*;
#(
    parameter int N = SPM_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
`ifdef SPM_UNSIGNED_MODE_EN
    input  logic             sgn_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output state_t           o_dbg_state
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign;
    logic [N-1:0]     r_mag_a;
    logic             r_busy;
    logic             r_done;
    logic [2*N-1:0]   r_product;

    logic             w_signed;
    logic             w_accept;
    logic             w_step;
    logic [N-1:0]     w_mag_a;
    logic [N-1:0]     w_mag_b;
    logic [2*N-1:0]   w_acc;
    logic [2*N-1:0]   w_neg;

`ifdef SPM_UNSIGNED_MODE_EN
    assign w_signed = sgn_mode;
`else
    assign w_signed = 1'b1;
`endif

    assign w_accept = (r_state == IDLE) && start;
    assign w_step   = (r_state == MUL);

    // Magnitude of the most negative value wraps to 2^(N-1), which is exactly
    // right when read as unsigned.
    assign w_mag_a = (w_signed && multiplicand[N-1]) ? (~multiplicand + N'(1)) : multiplicand;
    assign w_mag_b = (w_signed && multiplier[N-1])   ? (~multiplier + N'(1))   : multiplier;

    assign w_neg = ~w_acc + (2*N)'(1);

    spm_shift_add_core #(
        .N (N)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_mcand  (r_mag_a),
        .i_mplier (w_mag_b),
        .o_acc    (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_mag_a   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign  <= w_signed & (multiplicand[N-1] ^ multiplier[N-1]);
                        r_mag_a <= w_mag_a;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    // A zero magnitude negates back to zero, so no special case.
                    r_product <= r_sign ? w_neg : w_acc;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign product     = r_product;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spm_signed_ctrl.sv
module tb_spm_signed_ctrl;
  import spm_pkg::*;

  localparam int N = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [7:0]   mcand = '0;
  logic [7:0]   mplier = '0;
  logic         sgn_mode = 1'b1;
  logic         busy;
  logic         done;
  logic [15:0]  product;
  state_t       dbg_state;

  spm_signed_ctrl #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
`ifdef SPM_UNSIGNED_MODE_EN
    .sgn_mode     (sgn_mode),
`endif
    .busy         (busy),
    .done         (done),
    .product      (product),
    .o_dbg_state  (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference: integer multiply, signed or unsigned interpretation
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    int p;
    if (sgn) p = int'($signed(a)) * int'($signed(b));
    else     p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  // drive one operation, check busy each cycle, done latency/width, product
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                        input logic [15:0] exp, input string name);
    int lat;
    bit seen;
    logic [15:0] e;
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b; sgn_mode = sgn;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mcand = 8'($urandom); mplier = 8'($urandom); sgn_mode = 1'($urandom);
    check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
    lat = 1; seen = 0;
    while (lat <= 20 && !seen) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen = 1;
      else begin
        if (busy !== 1'b1) check({name, "_busy_hold"}, {31'd0, busy}, 32'd1);
        lat++;
      end
    end
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_latency"}, lat, 32'd9);
    check({name, "_busy_fall"}, {31'd0, busy}, 32'd0);
    if (exp_q.size() == 0) begin
      check({name, "_exp_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_product"}, {16'd0, product}, {16'd0, e});
    end
    @(posedge clk);
    @(negedge clk);
    check({name, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t tab[$];

  initial begin
    int bad;
    logic [7:0] ra, rb;
    logic rs;

    // reset block
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", {16'd0, product}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst = 1'b0;

    // directed table
    tab.push_back('{8'd7,   8'd9,   1'b1, 16'h003F, "7x9"});
    tab.push_back('{8'h80,  8'h80,  1'b1, 16'h4000, "m128xm128"});
    tab.push_back('{8'h80,  8'h7F,  1'b1, 16'hC080, "m128x127"});
    tab.push_back('{8'hFF,  8'h00,  1'b1, 16'h0000, "m1x0"});
    tab.push_back('{8'h00,  8'h80,  1'b1, 16'h0000, "0xm128"});
    tab.push_back('{8'h01,  8'hFF,  1'b1, 16'hFFFF, "1xm1"});
    tab.push_back('{8'h81,  8'h81,  1'b1, 16'h3F01, "m127xm127"});
    tab.push_back('{8'h7F,  8'h80,  1'b1, 16'hC080, "127xm128"});
`ifdef SPM_UNSIGNED_MODE_EN
    tab.push_back('{8'hFF,  8'hFF,  1'b0, 16'hFE01, "u_FFxFF"});
    tab.push_back('{8'hFF,  8'hFF,  1'b1, 16'h0001, "s_FFxFF"});
    tab.push_back('{8'h80,  8'h80,  1'b0, 16'h4000, "u_80x80"});
`endif
    for (int i = 0; i < tab.size(); i++)
      run_op(tab[i].a, tab[i].b, tab[i].sgn, tab[i].exp, tab[i].name);

    // back-to-back: start held high through busy, new operands in done cycle
    @(negedge clk);
    start = 1'b1; mcand = 8'd5; mplier = 8'd6; sgn_mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mcand = 8'd3; mplier = 8'hFB;          // start stays high; must be ignored
    bad = 0;
    for (int k = 1; k < 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("b2b_first_no_early_done", bad, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_product", {16'd0, product}, 32'h001E);
    // done cycle: start still high with 3 x -5, accepted on the next edge
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    bad = 0;
    for (int k = 1; k < 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || product !== 16'h001E) bad++;
    end
    check("b2b_product_hold", bad, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_second_done", {31'd0, done}, 32'd1);
    check("b2b_second_product", {16'd0, product}, 32'hFFF1);

    // reset during MUL (rst sampled on the 4th MUL edge)
    @(negedge clk);
    start = 1'b1; mcand = 8'd7; mplier = 8'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midrst_pre_state", {30'd0, dbg_state}, {30'd0, MUL});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_product", {16'd0, product}, 32'd0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midrst_no_done", bad, 32'd0);
    run_op(8'd2, 8'hFD, 1'b1, 16'hFFFA, "post_rst_2xm3");

    // start and rst on the same edge: rst wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; mcand = 8'd4; mplier = 8'd4;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_wins_busy", {31'd0, busy}, 32'd0);
    check("rst_wins_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(0, 255));
`ifdef SPM_UNSIGNED_MODE_EN
      rs = 1'($urandom);
`else
      rs = 1'b1;
`endif
      if (i % 8 == 0) ra = 8'h80;
      run_op(ra, rb, rs, model(ra, rb, rs), "rand");
    end

    check("exp_q_drained", exp_q.size(), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
